// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
//   Shared constants and types for the instruction cache and its way replacer.
//   Geometry: 8 sets x 8 ways, 4 x 32-bit words per line.
//   Address split: tag = addr[31:7], idx = addr[6:4], word = addr[3:2],
//   byte offset = addr[1:0].
// -----------------------------------------------------------------------------
package icache_pkg;

    localparam int NSET       = 8;
    localparam int NWAY       = 8;
    localparam int LINE_WORDS = 4;

    localparam int IDX_W  = $clog2(NSET);
    localparam int WAY_W  = $clog2(NWAY);
    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int BOFF_W = 2;
    localparam int TAG_W  = 32 - IDX_W - WORD_W - BOFF_W;

    // Fixed AXI4 read-burst attributes for a line refill.
    localparam logic [7:0] AXI_LEN   = 8'(LINE_WORDS - 1);
    localparam logic [2:0] AXI_SIZE  = 3'b010;
    localparam logic [1:0] AXI_BURST = 2'b01;

    // Slicing a fetch address is a plain cast onto this struct.
    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [IDX_W-1:0]  idx;
        logic [WORD_W-1:0] word;
        logic [BOFF_W-1:0] boff;
    } addr_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_AR     = 3'd2,
        S_R      = 3'd3,
        S_RESP   = 3'd4,
        S_FLUSH  = 3'd5
    } state_t;

    function automatic addr_t addr_split(input logic [31:0] addr);
        return addr_t'(addr);
    endfunction

    // Line-aligned byte address of a line.
    function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag,
                                              input logic [IDX_W-1:0] idx);
        return {tag, idx, {(WORD_W + BOFF_W){1'b0}}};
    endfunction

endpackage

// File: rtl/icache_tag_cmp.sv
// -----------------------------------------------------------------------------
// icache_tag_cmp
//   Parallel compare of one set's tags against a lookup tag.
//   Ports:
//     i_set_tags   NWAY*TAG_W  tags of the selected set, way 0 in the LSBs
//     i_set_valid  NWAY        valid bits of the selected set
//     i_tag        TAG_W       tag being looked up
//     o_hit        1           exactly one valid way matches
//     o_way        WAY_W       binary index of the matching way
// -----------------------------------------------------------------------------
module icache_tag_cmp
    import icache_pkg::*;
(
    input  logic [NWAY*TAG_W-1:0] i_set_tags,
    input  logic [NWAY-1:0]       i_set_valid,
    input  logic [TAG_W-1:0]      i_tag,
    output logic                  o_hit,
    output logic [WAY_W-1:0]      o_way
);

    logic [NWAY-1:0] w_match;

    always_comb begin
        w_match = '0;
        for (int i = 0; i < NWAY; i++) begin
            w_match[i] = i_set_valid[i] && (i_set_tags[i*TAG_W +: TAG_W] == i_tag);
        end
    end

    // A duplicated tag would be a corrupted set; treat it as a miss so the
    // line is refetched rather than returning an ambiguous word.
    assign o_hit = (w_match != '0) && ((w_match & (w_match - NWAY'(1))) == '0);

    always_comb begin
        o_way = '0;
        for (int i = 0; i < NWAY; i++) begin
            if (w_match[i]) begin
                o_way = o_way | WAY_W'(i);
            end
        end
    end

endmodule

// File: rtl/icache_refill.sv
// -----------------------------------------------------------------------------
// icache_refill
//   Instruction-cache lookup and refill controller. Looks a fetch up in an
//   8-way set-associative array held in flops, refills misses with an AXI4
//   INCR read burst, reports the outcome to the way replacer, and runs a
//   set-by-set invalidation sweep on fence_i.
//   Ports:
//     clock, reset                   clock, synchronous active-high reset
//     req_valid/req_ready/req_addr   fetch request from the IFU
//     rsp_valid/rsp_ready            response handshake
//     rsp_data, rsp_err              instruction word, refill bus error
//     fence_i                        start invalidation sweep (IDLE only)
//     busy                           controller not in IDLE
//     arvalid/arready/araddr         AXI read address channel
//     arlen/arsize/arburst           fixed burst attributes
//     rvalid/rready/rdata/rresp/rlast AXI read data channel
//     repl_idx/repl_way              set/way select toward the replacer
//     repl_access/repl_invalid       one-cycle replacer update pulses
//     repl_way_i                     replacer victim for repl_idx
// -----------------------------------------------------------------------------
module icache_refill
    import icache_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    input  logic        fence_i,
    output logic        busy,
    output logic        arvalid,
    input  logic        arready,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    input  logic        rvalid,
    output logic        rready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    output logic [2:0]  repl_idx,
    output logic [2:0]  repl_way,
    output logic        repl_access,
    output logic        repl_invalid,
    input  logic [2:0]  repl_way_i
);

    // Control state (reset)
    state_t            r_state;
    state_t            w_state_nxt;
    logic [NWAY-1:0]   r_valid [NSET];
    logic              r_err;
    logic [WORD_W-1:0] r_beat;
    logic [5:0]        r_flush_cnt;

    // Datapath state (no reset)
    logic [TAG_W-1:0]  r_req_tag;
    logic [IDX_W-1:0]  r_req_idx;
    logic [WORD_W-1:0] r_req_word;
    logic [WAY_W-1:0]  r_victim;
    logic [31:0]       r_rsp_data;
    logic [31:0]       r_buf  [LINE_WORDS];
    logic [TAG_W-1:0]  r_tags [NSET][NWAY];
    logic [31:0]       r_data [NSET][NWAY][LINE_WORDS];

    addr_t                w_req;
    logic [BOFF_W-1:0]    w_unused_boff;
    logic [NWAY*TAG_W-1:0] w_set_tags;
    logic                 w_hit;
    logic [WAY_W-1:0]     w_hit_way;
    logic                 w_accept;
    logic                 w_last_beat;
    logic                 w_err_final;

    assign w_req         = addr_split(req_addr);
    assign w_unused_boff = w_req.boff;

    // A request is only taken in IDLE when no fence is pending.
    assign w_accept    = (r_state == S_IDLE) && req_valid && !fence_i;
    assign w_last_beat = (r_state == S_R) && rvalid && rlast;
    // Error state including the beat on the wire this cycle.
    assign w_err_final = r_err || (rresp != 2'b00);

    always_comb begin
        w_set_tags = '0;
        for (int i = 0; i < NWAY; i++) begin
            w_set_tags[i*TAG_W +: TAG_W] = r_tags[r_req_idx][i];
        end
    end

    icache_tag_cmp u_tag_cmp (
        .i_set_tags  (w_set_tags),
        .i_set_valid (r_valid[r_req_idx]),
        .i_tag       (r_req_tag),
        .o_hit       (w_hit),
        .o_way       (w_hit_way)
    );

    // ---------------------------------------------------------------------
    // Next state and handshake / replacer outputs
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        req_ready    = 1'b0;
        arvalid      = 1'b0;
        rready       = 1'b0;
        rsp_valid    = 1'b0;
        repl_access  = 1'b0;
        repl_invalid = 1'b0;
        repl_idx     = '0;
        repl_way     = '0;
        busy         = 1'b1;

        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                // Holding ready low under fence_i keeps a simultaneous
                // request from being handshaken and then dropped.
                req_ready = !fence_i;
                if (fence_i) begin
                    w_state_nxt = S_FLUSH;
                end else if (req_valid) begin
                    w_state_nxt = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                repl_idx = r_req_idx;
                if (w_hit) begin
                    repl_access = 1'b1;
                    repl_way    = w_hit_way;
                    w_state_nxt = S_RESP;
                end else begin
                    w_state_nxt = S_AR;
                end
            end
            S_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    w_state_nxt = S_R;
                end
            end
            S_R: begin
                rready   = 1'b1;
                repl_idx = r_req_idx;
                repl_way = r_victim;
                if (w_last_beat) begin
                    if (w_err_final) begin
                        repl_invalid = 1'b1;
                    end else begin
                        repl_access = 1'b1;
                    end
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FLUSH: begin
                repl_invalid = 1'b1;
                {repl_idx, repl_way} = r_flush_cnt;
                if (r_flush_cnt == 6'd63) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign rsp_data = (r_state == S_RESP) ? r_rsp_data : 32'd0;
    assign rsp_err  = (r_state == S_RESP) && r_err;
    assign araddr   = (r_state == S_AR) ? line_addr(r_req_tag, r_req_idx) : 32'd0;
    assign arlen    = AXI_LEN;
    assign arsize   = AXI_SIZE;
    assign arburst  = AXI_BURST;

    // ---------------------------------------------------------------------
    // Control registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_err       <= 1'b0;
            r_beat      <= '0;
            r_flush_cnt <= '0;
            for (int s = 0; s < NSET; s++) begin
                r_valid[s] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (fence_i) begin
                        r_flush_cnt <= '0;
                    end
                end
                S_AR: begin
                    if (arready) begin
                        r_beat <= '0;
                    end
                end
                S_R: begin
                    if (rvalid) begin
                        r_beat <= r_beat + WORD_W'(1);
                        if (rresp != 2'b00) begin
                            r_err <= 1'b1;
                        end
                        if (rlast) begin
                            r_valid[r_req_idx][r_victim] <= !w_err_final;
                        end
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_err <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    r_valid[r_flush_cnt[5:3]][r_flush_cnt[2:0]] <= 1'b0;
                    r_flush_cnt <= r_flush_cnt + 6'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Datapath registers: request latch, line buffer, tag/data arrays
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_req_tag  <= w_req.tag;
            r_req_idx  <= w_req.idx;
            r_req_word <= w_req.word;
        end

        if (r_state == S_LOOKUP) begin
            if (w_hit) begin
                r_rsp_data <= r_data[r_req_idx][w_hit_way][r_req_word];
            end else begin
                r_victim <= repl_way_i;
            end
        end

        if ((r_state == S_R) && rvalid) begin
            r_buf[r_beat] <= rdata;
            if (rlast) begin
                // The final beat is not in the buffer yet; forward it.
                r_rsp_data <= (r_beat == r_req_word) ? rdata : r_buf[r_req_word];
                if (!w_err_final) begin
                    r_tags[r_req_idx][r_victim] <= r_req_tag;
                    for (int w = 0; w < LINE_WORDS; w++) begin
                        r_data[r_req_idx][r_victim][w] <=
                            (WORD_W'(w) == r_beat) ? rdata : r_buf[w];
                    end
                end
            end
        end
    end

endmodule
